// File: rtl/sm_board_pkg.sv
// Board-level constants and helpers shared by the sequencing/debounce blocks.
package sm_board_pkg;

    localparam int SM_DEBOUNCE_20MS_50MHZ = 1000000;

    // Width that holds every count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sm_debounce_bit.sv
// One debounced input: 2-flop synchronizer, non-wrapping stability counter, stable flop.
// Edge pulse flops exist only when SM_DEBOUNCE_EDGE_EN is defined.
module sm_debounce_bit
    import sm_board_pkg::*;
#(
    parameter int   CNT_MAX = SM_DEBOUNCE_20MS_50MHZ,
    parameter logic INIT    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          stable_next;
    logic          load;

    // The counter tops out at CNT_MAX-1 and is cleared on load, so it never wraps.
    always_comb begin
        cnt_next    = cnt;
        stable_next = stable;
        load        = 1'b0;
        if (sync2 == stable) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            load        = 1'b1;
            stable_next = sync2;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= INIT;
            sync2  <= INIT;
            stable <= INIT;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

`ifdef SM_DEBOUNCE_EDGE_EN
    // Pulses are loaded on the same edge as stable, so they line up with the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= load &  sync2;
            fall <= load & ~sync2;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sm_debounce.sv
// Multi-bit debouncer for KEY/SW/GPIO inputs; each bit is handled independently.
// Define SM_DEBOUNCE_EDGE_EN to build the rise/fall pulse outputs (otherwise tied to 0).
module sm_debounce
    import sm_board_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               CNT_MAX = SM_DEBOUNCE_20MS_50MHZ,
    parameter logic [WIDTH-1:0] INIT    = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sm_debounce_bit #(
            .CNT_MAX (CNT_MAX),
            .INIT    (INIT[i])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_in[i]),
            .stable (stable_out[i]),
            .rise   (rise_out[i]),
            .fall   (fall_out[i])
        );
    end

endmodule

// File: doc/sm_debounce.md
SM_DEBOUNCE -- requirements
Module: sm_debounce

Interface
- REQ-001: Parameter WIDTH, default 4; number of independent raw input bits.
- REQ-002: Parameter CNT_MAX, default 1000000; stability window in clk cycles (20 ms at 50 MHz); legal range is at least 1.
- REQ-003: Parameter INIT, default all ones (WIDTH bits); stable level after reset, matching the idle level of the active-low KEY inputs.
- REQ-004: clk, input, 1 bit; single clock, all logic on its rising edge.
- REQ-005: rst, input, 1 bit; synchronous, active-high reset.
- REQ-006: raw_in, input, WIDTH bits; asynchronous bouncing inputs from KEY, SW or GPIO.
- REQ-007: stable_out, output, WIDTH bits; debounced level.
- REQ-008: rise_out, output, WIDTH bits; one-cycle pulse when a stable_out bit goes 0->1.
- REQ-009: fall_out, output, WIDTH bits; one-cycle pulse when a stable_out bit goes 1->0.

Function
- REQ-010: Each raw_in bit shall pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
- REQ-011: Each bit shall own a counter of width $clog2(CNT_MAX+1) that never wraps.
- REQ-012: Per bit, when sync2 equals stable, the counter shall clear to 0.
- REQ-013: Per bit, when sync2 differs from stable and the counter is below CNT_MAX-1, the counter shall increment.
- REQ-014: Per bit, when sync2 differs from stable and the counter equals CNT_MAX-1, stable shall load sync2 and the counter shall clear, in the same edge.
- REQ-015: A raw change held constant shall appear on stable_out exactly CNT_MAX+2 cycles after the first edge that samples it.
- REQ-016: Any return of sync2 to stable before the window completes shall discard the partial count, so a bounce restarts the window.
- REQ-017: rise_out and fall_out shall be registered, asserted for exactly one cycle, and aligned with the cycle in which stable_out first shows the new value.
- REQ-018: rise_out and fall_out for the same bit shall never assert simultaneously.
- REQ-019: Bits shall be fully independent; simultaneous changes on several bits shall each produce their own pulse in the same cycle.
- REQ-020: With CNT_MAX=1, stable shall update on the first edge at which sync2 differs from stable, giving a latency of 3.

Reset
- REQ-021: While rst=1 at a clk edge: sync1, sync2 and stable_out shall load INIT; counters shall load 0; rise_out and fall_out shall load 0.
- REQ-022: Reset asserted mid-window shall abandon the count; no pulse shall be generated for the abandoned change.
- REQ-023: No pulse shall be generated on the first cycle after reset, even if raw_in differs from INIT; that difference starts a normal window.

Configuration
- REQ-024: Macro SM_DEBOUNCE_EDGE_EN defined: rise_out and fall_out behave per REQ-017 to REQ-019.
- REQ-025: Macro SM_DEBOUNCE_EDGE_EN undefined: rise_out and fall_out shall be constant 0, and their pulse flops shall not be built.
- REQ-026: The port list shall be identical with and without the macro.

Structure
- REQ-027: Shared package sm_board_pkg shall hold the constant SM_DEBOUNCE_20MS_50MHZ = 1000000 and the counter-width function.
- REQ-028: Per-bit logic (synchronizer, counter, stable flop, edge flops) shall be the sub-module sm_debounce_bit, instantiated WIDTH times in a generate loop.

Verification (bench uses WIDTH=4, CNT_MAX=4, INIT=4'hF)
- REQ-029: Reset, then raw_in=4'hF held -> stable_out=4'hF, no pulses for 20 cycles.
- REQ-030: raw_in[0] 1->0 held -> stable_out[0]=0 exactly 6 cycles later; fall_out=4'h1 for exactly that one cycle.
- REQ-031: raw_in[1] toggles 1->0->1->0 every 2 cycles, then held 0 -> no change until 6 cycles after the final toggle; then a single fall_out[1] pulse.
- REQ-032: raw_in 4'hF->4'h0 on all bits at once -> fall_out=4'hF in one cycle; later 4'h0->4'hF -> rise_out=4'hF in one cycle.
- REQ-033: raw_in[2] changes, rst pulsed at cycle 4 -> stable_out[2] stays 1, no pulse; a new window then completes 6 cycles after reset release.
- REQ-034: Build without SM_DEBOUNCE_EDGE_EN, repeat REQ-030 -> stable_out timing unchanged; rise_out and fall_out stay 0.
